// File: rtl/pulse_extend_arb.sv
// -----------------------------------------------------------------------------
// pulse_extend_arb
//
// Collects single-cycle request pulses from REQ_NUM requesters, arbitrates
// between them round-robin, and stretches the winner's valid into a window of
// exactly EXTEND_CYC_NUM cycles. The requester's data bit (captured with its
// pulse) is presented for the whole window. Every window ends with a one-cycle
// o_done pulse, during which o_vld is low. The next grant is decided in the
// IDLE cycle that follows.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        grant enable; when low no new window starts (a running window
//               still completes, and requests keep latching)
//   i_req_vld   [REQ_NUM]  per-requester request pulse
//   i_req_data  [REQ_NUM]  per-requester data bit, sampled with i_req_vld
//   o_vld       extended valid of the granted requester
//   o_vld_data  latched data of the granted requester, low outside a window
//   o_id        [ID_W]     index of the current or most recent grant
//   o_done      one-cycle pulse after the last o_vld cycle of a window
//   o_pend      [REQ_NUM]  pending-request flags
//   o_busy      high while a window is running
// -----------------------------------------------------------------------------
module pulse_extend_arb #(
    parameter int REQ_NUM        = 4,
    parameter int EXTEND_CYC_NUM = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_en,
    input  logic [REQ_NUM-1:0]         i_req_vld,
    input  logic [REQ_NUM-1:0]         i_req_data,
    output logic                       o_vld,
    output logic                       o_vld_data,
    output logic [$clog2(REQ_NUM)-1:0] o_id,
    output logic                       o_done,
    output logic [REQ_NUM-1:0]         o_pend,
    output logic                       o_busy
);

    localparam int ID_W  = $clog2(REQ_NUM);
    localparam int CNT_W = (EXTEND_CYC_NUM == 1) ? 1 : $clog2(EXTEND_CYC_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXTEND_CYC_NUM - 1);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(REQ_NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXT  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [REQ_NUM-1:0] pend_q;
    logic [REQ_NUM-1:0] data_lat_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               vld_q;
    logic               vld_data_q;
    logic               done_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [REQ_NUM-1:0] win_oh;
    logic [ID_W-1:0]    scan_id;
    logic               grant;
    logic               win_end;
    logic [REQ_NUM-1:0] clr_mask;

    // Round-robin search: start just after the last winner, wrap at REQ_NUM-1,
    // the first pending requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_oh    = '0;
        scan_id   = last_id_q;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (scan_id == ID_MAX) begin
                scan_id = '0;
            end else begin
                scan_id = scan_id + ID_W'(1);
            end
            if (!win_found && pend_q[scan_id]) begin
                win_found       = 1'b1;
                win_id          = scan_id;
                win_oh[scan_id] = 1'b1;
            end
        end
    end

    // Control FSM: next state and the grant / end-of-window strobes.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_en && win_found) begin
                    grant   = 1'b1;
                    state_d = EXT;
                end
            end
            EXT: begin
                if (cnt_q == CNT_LAST) begin
                    win_end = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new pulse on the granted requester's own line wins over the grant
    // clear, so that pulse stays pending for a later window.
    assign clr_mask = grant ? win_oh : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q     <= '0;
            data_lat_q <= '0;
            id_q       <= '0;
            last_id_q  <= ID_MAX;
            cnt_q      <= '0;
            vld_q      <= 1'b0;
            vld_data_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pend_q     <= (pend_q & ~clr_mask) | i_req_vld;
            data_lat_q <= (data_lat_q & ~i_req_vld) | (i_req_data & i_req_vld);
            done_q     <= win_end;
            if (grant) begin
                // Window data is taken from the latch before this edge's update,
                // so a same-edge re-pulse only affects the next window.
                vld_q      <= 1'b1;
                vld_data_q <= data_lat_q[win_id];
                id_q       <= win_id;
                last_id_q  <= win_id;
                cnt_q      <= '0;
            end else if (win_end) begin
                vld_q      <= 1'b0;
                vld_data_q <= 1'b0;
            end else if (state_q == EXT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_vld      = vld_q;
    assign o_vld_data = vld_data_q;
    assign o_id       = id_q;
    assign o_done     = done_q;
    assign o_pend     = pend_q;
    assign o_busy     = (state_q == EXT);

endmodule
